// File: rtl/one_adder.sv
// 1-bit full adder with registered sum/carry and an internal carry register that
// can stand in for c_in, so multi-bit operands can be added LSB-first one bit per clock.
module one_adder (
    input  logic clk,
    input  logic rst,
    input  logic c_in,
    input  logic a,
    input  logic b,
    input  logic serial_en,
    output logic s,
    output logic c_out,
    output logic s_q,
    output logic c_out_q,
    output logic carry_q
);

    logic cin_eff;

    // Serial mode feeds back the previous bit's carry instead of the external carry-in.
    assign cin_eff = serial_en ? carry_q : c_in;

    assign s     = a ^ b ^ cin_eff;
    assign c_out = (a & b) | (a & cin_eff) | (b & cin_eff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= 1'b0;
            c_out_q <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            s_q     <= s;
            c_out_q <= c_out;
            carry_q <= c_out;
        end
    end

endmodule

// File: tb/tb_one_adder.sv
// Randomized and directed checks of one_adder against an arithmetic reference model
// that tracks the serial carry explicitly.
module tb_one_adder;

    logic clk = 1'b0;
    logic rst;
    logic c_in, a, b, serial_en;
    logic s, c_out, s_q, c_out_q, carry_q;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: registered outputs and carry as the spec defines them.
    logic m_sq, m_cq, m_carry;

    one_adder u_dut (
        .clk       (clk),
        .rst       (rst),
        .c_in      (c_in),
        .a         (a),
        .b         (b),
        .serial_en (serial_en),
        .s         (s),
        .c_out     (c_out),
        .s_q       (s_q),
        .c_out_q   (c_out_q),
        .carry_q   (carry_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {carry, sum} of three bits computed as a plain integer sum.
    function automatic logic [1:0] ref_add(input logic x, input logic y, input logic ci);
        int t;
        t = int'(x) + int'(y) + int'(ci);
        return t[1:0];
    endfunction

    // Drive one bit, check combinational outputs, clock it in, check registered outputs.
    task automatic apply(input logic ci, input logic xa, input logic xb, input logic se,
                         output logic obs_s, output logic obs_c);
        logic [1:0] r;
        c_in = ci; a = xa; b = xb; serial_en = se;
        #1;
        r = ref_add(xa, xb, se ? m_carry : ci);
        check("s", {7'd0, s}, {7'd0, r[0]});
        check("c_out", {7'd0, c_out}, {7'd0, r[1]});
        obs_s = s;
        obs_c = c_out;
        @(posedge clk);
        #1;
        m_sq = r[0]; m_cq = r[1]; m_carry = r[1];
        check("s_q", {7'd0, s_q}, {7'd0, m_sq});
        check("c_out_q", {7'd0, c_out_q}, {7'd0, m_cq});
        check("carry_q", {7'd0, carry_q}, {7'd0, m_carry});
    endtask

    task automatic serial_add(input logic [3:0] x, input logic [3:0] y, input logic ci0);
        logic [3:0] sum_bits;
        logic       last_c, os, oc;
        int         total;
        for (int i = 0; i < 4; i++) begin
            apply(ci0, x[i], y[i], i != 0, os, oc);
            sum_bits[i] = os;
            last_c = oc;
        end
        total = int'(x) + int'(y) + int'(ci0);
        check("serial_sum", {4'd0, sum_bits}, total[7:0] & 8'h0f);
        check("serial_cout", {7'd0, last_c}, {7'd0, total[4]});
    endtask

    task automatic pulse_reset;
        #2 rst = 1'b1;
        #1;
        m_sq = 1'b0; m_cq = 1'b0; m_carry = 1'b0;
        check("rst_s_q", {7'd0, s_q}, 8'd0);
        check("rst_c_out_q", {7'd0, c_out_q}, 8'd0);
        check("rst_carry_q", {7'd0, carry_q}, 8'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic os, oc;
        logic [3:0] x, y;
        rst = 1'b1; c_in = 1'b0; a = 1'b0; b = 1'b0; serial_en = 1'b0;
        m_sq = 1'b0; m_cq = 1'b0; m_carry = 1'b0;
        #12;
        check("reset_s_q", {7'd0, s_q}, 8'd0);
        check("reset_c_out_q", {7'd0, c_out_q}, 8'd0);
        check("reset_carry_q", {7'd0, carry_q}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Truth table sweep, order (c_in,a,b); constants cross-check the model.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            apply(v[2], v[1], v[0], 1'b0, os, oc);
            check("tt_s", {7'd0, os}, {7'd0, ^v});
            check("tt_c", {7'd0, oc}, {7'd0, (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])});
        end

        // Register latency: 1+1+0 lands after one edge and holds until the next.
        apply(1'b0, 1'b1, 1'b1, 1'b0, os, oc);
        check("lat_s_q", {7'd0, s_q}, 8'd0);
        check("lat_c_out_q", {7'd0, c_out_q}, 8'd1);
        #3;
        check("lat_hold_carry_q", {7'd0, carry_q}, 8'd1);
        check("lat_hold_c_out_q", {7'd0, c_out_q}, 8'd1);

        serial_add(4'b0111, 4'b0101, 1'b0);
        serial_add(4'b1111, 4'b0001, 1'b0);
        check("ovf_carry_q", {7'd0, carry_q}, 8'd1);

        // Async reset with carry set, then serial mode sees carry_q=0.
        apply(1'b0, 1'b1, 1'b1, 1'b0, os, oc);
        pulse_reset();
        serial_en = 1'b1; a = 1'b1; b = 1'b0; c_in = 1'b1;
        #1;
        check("post_rst_s", {7'd0, s}, 8'd1);
        check("post_rst_c_out", {7'd0, c_out}, 8'd0);

        // Mode switch with no clock edge in between.
        @(posedge clk); #1;
        apply(1'b0, 1'b1, 1'b1, 1'b0, os, oc);
        a = 1'b0; b = 1'b0; c_in = 1'b0; serial_en = 1'b0;
        #1;
        check("mode_s_par", {7'd0, s}, 8'd0);
        serial_en = 1'b1;
        #1;
        check("mode_s_ser", {7'd0, s}, 8'd1);
        @(posedge clk); #1;
        m_sq = 1'b1; m_cq = 1'b0; m_carry = 1'b0;
        check("mode_edge_s_q", {7'd0, s_q}, 8'd1);

        // Random single bits with occasional reset pulses.
        for (int i = 0; i < 200; i++) begin
            apply(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), os, oc);
            if ($urandom_range(0, 19) == 0) pulse_reset();
        end

        // Random 4-bit serial adds, with and without initial carry.
        for (int i = 0; i < 20; i++) begin
            x = 4'($urandom);
            y = 4'($urandom);
            serial_add(x, y, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/one_adder.md
Name: one_adder

Overview:
- 1-bit full adder with a combinational sum/carry path and registered copies of both results.
- Also usable as a bit-serial adder: an internal carry register can replace the external carry-in, so multi-bit operands can be added LSB-first, one bit per clock.
- Leaf arithmetic cell, instantiated wherever single-bit add or bit-serial add is needed.

Parameters:
- none (fixed 1-bit datapath)

Ports:
- clk  input  1  rising-edge clock for all registers
- rst  input  1  asynchronous, active-high reset
- c_in  input  1  external carry-in
- a  input  1  operand bit A
- b  input  1  operand bit B
- serial_en  input  1  1 = carry-in taken from internal carry register (bit-serial mode); 0 = carry-in taken from c_in
- s  output  1  combinational sum
- c_out  output  1  combinational carry-out
- s_q  output  1  registered sum
- c_out_q  output  1  registered carry-out
- carry_q  output  1  internal carry register (serial carry state)

Behaviour:
- Effective carry: cin_eff = serial_en ? carry_q : c_in.
- Combinational outputs, zero latency, purely from current inputs and carry_q:
  - s = a XOR b XOR cin_eff
  - c_out = (a AND b) OR (a AND cin_eff) OR (b AND cin_eff)
- Full truth table with serial_en=0, given as (c_in,a,b) -> (s,c_out):
  - 000->00, 010->10, 001->10, 011->01
  - 100->10, 110->01, 101->01, 111->11
- Registers, updated on rising clk edge, 1-cycle latency:
  - s_q <= s
  - c_out_q <= c_out
  - carry_q <= c_out
- carry_q always tracks the last c_out. In serial mode this makes the carry propagate bit to bit.
- Starting a serial add:
  - Present bit 0 with serial_en=0 and c_in set to the initial carry (0 for add, 1 for add-with-carry).
  - Hold serial_en=1 for all following bits.
- Reset, asynchronous on rst rising, held while rst=1:
  - s_q=0, c_out_q=0, carry_q=0.
  - Combinational s/c_out remain live during reset. With serial_en=1 they use carry_q=0.
- Reset mid serial operation: carry state is lost (carry_q=0). The operation must be restarted by the user.
- serial_en may change on any cycle. It only affects cin_eff. The effect is immediate on s/c_out and on the next edge for the registered outputs.
- No X-propagation masking. Inputs are sampled as-is at the clock edge.
- No handshake. The block accepts a new bit every cycle.

Test Plan:
- Combinational sweep: serial_en=0, apply all 8 (c_in,a,b) combos every 2 time units -> s/c_out match the truth table, e.g. 011->s=0,c_out=1 and 111->s=1,c_out=1.
- Register latency: serial_en=0, apply a=1,b=1,c_in=0 before an edge -> after that edge s_q=0, c_out_q=1, carry_q=1; values unchanged until the next edge.
- Bit-serial add 4'b0111+4'b0101, LSB first:
  - bit0 with serial_en=0,c_in=0; bits1-3 with serial_en=1.
  - Sampled s sequence 0,0,1,1 (=4'b1100); final c_out=0.
- Bit-serial overflow 4'b1111+4'b0001:
  - s sequence 0,0,0,0.
  - c_out=1 on every bit, carry_q=1 after the last edge.
- Async reset: set carry_q=1 via a=b=1, then pulse rst between clock edges -> s_q/c_out_q/carry_q go to 0 immediately; with serial_en=1,a=1,b=0 after reset, s=1,c_out=0.
- Mode switch: carry_q=1, a=b=0, c_in=0; toggle serial_en 0->1 -> s changes 0->1 combinationally with no clock edge.
